// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI slave endpoint.
// Mode encodings are {CPOL,CPHA} and must match the master on the same bus.
package spi_slave_pkg;

    localparam int WORD_LENGTH_DEFAULT = 8;

    localparam logic [1:0] MODE_POL_PHS_00 = 2'b00;
    localparam logic [1:0] MODE_POL_PHS_01 = 2'b01;
    localparam logic [1:0] MODE_POL_PHS_10 = 2'b10;
    localparam logic [1:0] MODE_POL_PHS_11 = 2'b11;

    localparam logic SPI_READY = 1'b1;
    localparam logic SPI_BUSY  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous bus line, with one-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples SCLK/SS_N/MOSI on clk, exchanges one word per
// frame, with a single-entry TX holding register and a pulsed RX output.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int         WORD_LENGTH = WORD_LENGTH_DEFAULT,
    parameter logic [1:0] SPI_MODE    = MODE_POL_PHS_00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sclk,
    input  logic                   ss_n,
    input  logic                   mosi,
    output logic                   miso,
    output logic                   miso_oe,
    input  logic [WORD_LENGTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [WORD_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   tx_underrun,
    output logic                   busy
);

    localparam logic             CPOL     = SPI_MODE[1];
    localparam logic             CPHA     = SPI_MODE[0];
    localparam int               CNT_W    = $clog2(WORD_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LENGTH - 1);

    spi_state_t state_q, state_d;

    logic unused_sclk_level, unused_ss_rise, unused_ss_fall;
    logic sclk_rise, sclk_fall, ss_q, mosi_q;
    logic sclk_lead, sclk_trail, sample_edge, shift_edge;
    logic load, sample, shift, accept;

    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WORD_LENGTH:0]   tx_shift;
    logic [WORD_LENGTH-1:0] rx_shift;
    logic [WORD_LENGTH-1:0] hold_data;
    logic [WORD_LENGTH-1:0] load_word;
    logic                   hold_full;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sclk),
        .q    (unused_sclk_level),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (ss_n),
        .q    (ss_q),
        .rise (unused_ss_rise),
        .fall (unused_ss_fall)
    );

    // MOSI gets the same depth as SCLK so its data lines up with the edge pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_q      = mosi_sync[SYNC_STAGES-1];
    assign sclk_lead   = CPOL ? sclk_fall : sclk_rise;
    assign sclk_trail  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? sclk_trail : sclk_lead;
    assign shift_edge  = CPHA ? sclk_lead : sclk_trail;

    assign accept    = tx_valid && tx_ready;
    assign load_word = hold_full ? hold_data : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In CPHA=0 the final trailing edge of a frame arrives after the next word
    // is loaded; a shift edge before any sample belongs to the previous word.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        sample  = 1'b0;
        shift   = 1'b0;
        if (ss_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (sample_edge) begin
                        sample = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state_d = DONE;
                        end
                    end
                    if (shift_edge && (CPHA || (bit_cnt != '0))) begin
                        shift = 1'b1;
                    end
                end
                DONE: begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
        end else if (ss_q) begin
            bit_cnt  <= '0;
            tx_shift <= '0;
        end else if (load) begin
            bit_cnt  <= '0;
            tx_shift <= CPHA ? {1'b0, load_word} : {load_word, 1'b0};
        end else begin
            if (sample) begin
                rx_shift <= {rx_shift[WORD_LENGTH-2:0], mosi_q};
                bit_cnt  <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    rx_data <= {rx_shift[WORD_LENGTH-2:0], mosi_q};
                end
            end
            if (shift) begin
                tx_shift <= {tx_shift[WORD_LENGTH-1:0], 1'b0};
            end
        end
    end

    // A load and an accept in the same cycle: the load takes the old word and
    // the new word refills the register that was just emptied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full   <= 1'b0;
            hold_data   <= '0;
            tx_underrun <= 1'b0;
        end else begin
            if (load) begin
                hold_full <= accept;
            end else if (accept) begin
                hold_full <= 1'b1;
            end
            if (accept) begin
                hold_data <= tx_data;
            end
            tx_underrun <= load && !hold_full;
        end
    end

    assign tx_ready = hold_full ? ~SPI_READY : SPI_READY;
    assign busy     = (state_q == SHIFT) ? SPI_BUSY : ~SPI_BUSY;
    assign rx_valid = (state_q == DONE);
    assign miso_oe  = ~ss_q;
    assign miso     = tx_shift[WORD_LENGTH];

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one DUT per SPI mode, driven by a small
// behavioural master; scenario tasks check their own expectations.
module tb_spi_slave;

    localparam int HALF = 4;

    logic       clk;
    logic       rst;
    logic       mosi;
    logic [7:0] tx_data;
    logic [3:0] sclk_v, ss_n_v, tx_valid_v;
    logic [3:0] miso_v, miso_oe_v, tx_ready_v, rx_valid_v, tx_underrun_v, busy_v;
    logic [7:0] rx_data_a [4];

    int checks = 0;
    int errors = 0;
    int rx_pulses [4] = '{default: 0};
    int ur_pulses [4] = '{default: 0};

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_slave #(.WORD_LENGTH(8), .SPI_MODE(2'(m)), .SYNC_STAGES(2)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .sclk        (sclk_v[m]),
            .ss_n        (ss_n_v[m]),
            .mosi        (mosi),
            .miso        (miso_v[m]),
            .miso_oe     (miso_oe_v[m]),
            .tx_data     (tx_data),
            .tx_valid    (tx_valid_v[m]),
            .tx_ready    (tx_ready_v[m]),
            .rx_data     (rx_data_a[m]),
            .rx_valid    (rx_valid_v[m]),
            .tx_underrun (tx_underrun_v[m]),
            .busy        (busy_v[m])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            rx_pulses[i] <= rx_pulses[i] + int'(rx_valid_v[i]);
            ur_pulses[i] <= ur_pulses[i] + int'(tx_underrun_v[i]);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input int m, input logic [7:0] word);
        @(negedge clk);
        tx_data       = word;
        tx_valid_v[m] = 1'b1;
        @(negedge clk);
        tx_valid_v[m] = 1'b0;
    endtask

    task automatic xfer(input int m, input logic [7:0] tx_word, input int nbits,
                        output logic [7:0] rx_word);
        logic cpol;
        logic cpha;
        cpol    = (m >= 2);
        cpha    = ((m % 2) == 1);
        rx_word = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi = tx_word[i];
                wait_clks(HALF);
                sclk_v[m]  = ~cpol;
                rx_word[i] = miso_v[m];
                wait_clks(HALF);
                sclk_v[m]  = cpol;
            end else begin
                sclk_v[m] = ~cpol;
                mosi      = tx_word[i];
                wait_clks(HALF);
                sclk_v[m]  = cpol;
                rx_word[i] = miso_v[m];
                wait_clks(HALF);
            end
        end
    endtask

    task automatic test_reset();
        wait_clks(3);
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (miso_v[m] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_miso[%0d]: got %b expected 0", m, miso_v[m]);
            end
            checks++;
            if (miso_oe_v[m] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_miso_oe[%0d]: got %b expected 0", m, miso_oe_v[m]);
            end
            checks++;
            if (tx_ready_v[m] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_tx_ready[%0d]: got %b expected 1", m, tx_ready_v[m]);
            end
            checks++;
            if (rx_data_a[m] !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_rx_data[%0d]: got %h expected 00", m, rx_data_a[m]);
            end
            checks++;
            if (rx_valid_v[m] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_rx_valid[%0d]: got %b expected 0", m, rx_valid_v[m]);
            end
            checks++;
            if (tx_underrun_v[m] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_tx_underrun[%0d]: got %b expected 0", m, tx_underrun_v[m]);
            end
            checks++;
            if (busy_v[m] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_busy[%0d]: got %b expected 0", m, busy_v[m]);
            end
        end
        rst = 1'b1;
        wait_clks(4);
    endtask

    task automatic test_mode0();
        logic [7:0] got;
        int         rx0;
        load_tx(0, 8'hA5);
        checks++;
        if (tx_ready_v[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mode0_tx_ready_full: got %b expected 0", tx_ready_v[0]);
        end
        rx0       = rx_pulses[0];
        ss_n_v[0] = 1'b0;
        wait_clks(6);
        checks++;
        if (tx_ready_v[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mode0_tx_ready_after_load: got %b expected 1", tx_ready_v[0]);
        end
        xfer(0, 8'h3C, 8, got);
        wait_clks(6);
        checks++;
        if (got !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL mode0_master_rx: got %h expected a5", got);
        end
        checks++;
        if (rx_data_a[0] !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL mode0_rx_data: got %h expected 3c", rx_data_a[0]);
        end
        checks++;
        if (rx_pulses[0] - rx0 !== 1) begin
            errors++;
            $display("[TB] FAIL mode0_rx_valid_pulses: got %0d expected 1", rx_pulses[0] - rx0);
        end
        ss_n_v[0] = 1'b1;
        wait_clks(6);
    endtask

    task automatic test_mode3();
        logic [7:0] got;
        int         rx0;
        load_tx(3, 8'h81);
        checks++;
        if (miso_oe_v[3] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mode3_oe_before: got %b expected 0", miso_oe_v[3]);
        end
        rx0       = rx_pulses[3];
        ss_n_v[3] = 1'b0;
        wait_clks(6);
        checks++;
        if (miso_oe_v[3] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mode3_oe_selected: got %b expected 1", miso_oe_v[3]);
        end
        xfer(3, 8'h7E, 8, got);
        wait_clks(6);
        checks++;
        if (got !== 8'h81) begin
            errors++;
            $display("[TB] FAIL mode3_master_rx: got %h expected 81", got);
        end
        checks++;
        if (rx_data_a[3] !== 8'h7E) begin
            errors++;
            $display("[TB] FAIL mode3_rx_data: got %h expected 7e", rx_data_a[3]);
        end
        checks++;
        if (rx_pulses[3] - rx0 !== 1) begin
            errors++;
            $display("[TB] FAIL mode3_rx_valid_pulses: got %0d expected 1", rx_pulses[3] - rx0);
        end
        ss_n_v[3] = 1'b1;
        wait_clks(6);
        checks++;
        if (miso_oe_v[3] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mode3_oe_after: got %b expected 0", miso_oe_v[3]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got1;
        logic [7:0] got2;
        int         rx0;
        for (int m = 1; m <= 2; m++) begin
            load_tx(m, 8'h12);
            rx0       = rx_pulses[m];
            ss_n_v[m] = 1'b0;
            wait_clks(6);
            fork
                xfer(m, 8'hA1, 8, got1);
                begin
                    wait_clks(20);
                    load_tx(m, 8'h34);
                end
            join
            wait_clks(6);
            checks++;
            if (rx_data_a[m] !== 8'hA1) begin
                errors++;
                $display("[TB] FAIL b2b_rx_data1[%0d]: got %h expected a1", m, rx_data_a[m]);
            end
            checks++;
            if (busy_v[m] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_busy_between[%0d]: got %b expected 1", m, busy_v[m]);
            end
            xfer(m, 8'hB2, 8, got2);
            wait_clks(6);
            checks++;
            if (got1 !== 8'h12) begin
                errors++;
                $display("[TB] FAIL b2b_master_rx1[%0d]: got %h expected 12", m, got1);
            end
            checks++;
            if (got2 !== 8'h34) begin
                errors++;
                $display("[TB] FAIL b2b_master_rx2[%0d]: got %h expected 34", m, got2);
            end
            checks++;
            if (rx_data_a[m] !== 8'hB2) begin
                errors++;
                $display("[TB] FAIL b2b_rx_data2[%0d]: got %h expected b2", m, rx_data_a[m]);
            end
            checks++;
            if (rx_pulses[m] - rx0 !== 2) begin
                errors++;
                $display("[TB] FAIL b2b_rx_valid_pulses[%0d]: got %0d expected 2", m, rx_pulses[m] - rx0);
            end
            ss_n_v[m] = 1'b1;
            wait_clks(6);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] got;
        int         ur0;
        ur0       = ur_pulses[0];
        ss_n_v[0] = 1'b0;
        wait_clks(6);
        checks++;
        if (ur_pulses[0] - ur0 !== 1) begin
            errors++;
            $display("[TB] FAIL underrun_pulses: got %0d expected 1", ur_pulses[0] - ur0);
        end
        xfer(0, 8'hFF, 8, got);
        wait_clks(6);
        checks++;
        if (got !== 8'h00) begin
            errors++;
            $display("[TB] FAIL underrun_master_rx: got %h expected 00", got);
        end
        checks++;
        if (rx_data_a[0] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL underrun_rx_data: got %h expected ff", rx_data_a[0]);
        end
        ss_n_v[0] = 1'b1;
        wait_clks(6);
    endtask

    task automatic test_abort();
        logic [7:0] got;
        int         rx0;
        rx0       = rx_pulses[0];
        ss_n_v[0] = 1'b0;
        wait_clks(6);
        xfer(0, 8'h00, 3, got);
        ss_n_v[0] = 1'b1;
        wait_clks(6);
        checks++;
        if (rx_pulses[0] - rx0 !== 0) begin
            errors++;
            $display("[TB] FAIL abort_rx_valid_pulses: got %0d expected 0", rx_pulses[0] - rx0);
        end
        checks++;
        if (busy_v[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_busy: got %b expected 0", busy_v[0]);
        end
        checks++;
        if (rx_data_a[0] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL abort_rx_data_held: got %h expected ff", rx_data_a[0]);
        end
        load_tx(0, 8'h5A);
        rx0       = rx_pulses[0];
        ss_n_v[0] = 1'b0;
        wait_clks(6);
        xfer(0, 8'h55, 8, got);
        wait_clks(6);
        checks++;
        if (got !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL abort_next_master_rx: got %h expected 5a", got);
        end
        checks++;
        if (rx_data_a[0] !== 8'h55) begin
            errors++;
            $display("[TB] FAIL abort_next_rx_data: got %h expected 55", rx_data_a[0]);
        end
        checks++;
        if (rx_pulses[0] - rx0 !== 1) begin
            errors++;
            $display("[TB] FAIL abort_next_pulses: got %0d expected 1", rx_pulses[0] - rx0);
        end
        ss_n_v[0] = 1'b1;
        wait_clks(6);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] got;
        load_tx(0, 8'h99);
        ss_n_v[0] = 1'b0;
        wait_clks(6);
        xfer(0, 8'hF0, 4, got);
        wait_clks(1);
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midframe_busy_before_reset: got %b expected 1", busy_v[0]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (miso_oe_v[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe_reset_miso_oe: got %b expected 0", miso_oe_v[0]);
        end
        checks++;
        if (miso_v[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe_reset_miso: got %b expected 0", miso_v[0]);
        end
        checks++;
        if (busy_v[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe_reset_busy: got %b expected 0", busy_v[0]);
        end
        checks++;
        if (rx_data_a[0] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midframe_reset_rx_data: got %h expected 00", rx_data_a[0]);
        end
        checks++;
        if (tx_ready_v[0] !== 1'b1 || rx_valid_v[0] !== 1'b0 || tx_underrun_v[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe_reset_flags: got ready=%b valid=%b underrun=%b expected 1 0 0",
                     tx_ready_v[0], rx_valid_v[0], tx_underrun_v[0]);
        end
        ss_n_v[0] = 1'b1;
        wait_clks(3);
        rst = 1'b1;
        wait_clks(4);
        load_tx(0, 8'h3C);
        ss_n_v[0] = 1'b0;
        wait_clks(6);
        xfer(0, 8'hC3, 8, got);
        wait_clks(6);
        checks++;
        if (got !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL post_reset_master_rx: got %h expected 3c", got);
        end
        checks++;
        if (rx_data_a[0] !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL post_reset_rx_data: got %h expected c3", rx_data_a[0]);
        end
        ss_n_v[0] = 1'b1;
        wait_clks(6);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        mosi       = 1'b0;
        tx_data    = 8'h00;
        tx_valid_v = 4'b0000;
        ss_n_v     = 4'b1111;
        sclk_v     = 4'b1100;
        $display("[TB] starting spi_slave bench");
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
